rob_commit_ctrl: RTL

Reorder-buffer controller that sequences the architectural register file.
- Allocates ROB ids at issue and drives the rename strobe.
- Collects CDB writebacks out of order and retires entries in program order onto the commit bus.
- Raises the global jump/flush on a mispredicted branch.
- Sits between the issue unit, the CDB and the register file, and answers operand-readiness queries for issue.

---
 rtl/rob_commit_ctrl_pkg.sv | 13 +
 rtl/rob_commit_ctrl_if.sv | 51 +++++
 rtl/rob_commit_ctrl_query_port.sv | 21 ++
 rtl/rob_commit_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rob_commit_ctrl_pkg.sv
// rtl/rob_commit_ctrl_pkg.sv - shared ROB sizing and id helpers
// ROB geometry shared with the register file; ids wrap naturally at ROB_SIZE.
package rob_commit_ctrl_pkg;
  localparam int ROB_LOG  = 4;
  localparam int ROB_SIZE = 1 << ROB_LOG;

  typedef logic [ROB_LOG-1:0] rob_id_t;
  typedef logic [ROB_LOG:0]   rob_cnt_t;

  function automatic rob_id_t id_inc(input rob_id_t id);
    return id + rob_id_t'(1);
  endfunction
endpackage

// File: rtl/rob_commit_ctrl_if.sv
// rtl/rob_commit_ctrl_if.sv - issue, CDB, query and commit bus of the ROB
// master = environment (issue unit, CDB, register file); slave = the ROB.
interface rob_commit_ctrl_if;
  import rob_commit_ctrl_pkg::*;

  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_is_branch;
  logic        issue_pred_taken;
  rob_id_t     issue_RobId;
  logic        rob_full;
  logic        rename_valid;

  logic        wb_valid;
  rob_id_t     wb_RobId;
  logic [31:0] wb_value;
  logic        wb_taken;
  logic [31:0] wb_target;

  rob_id_t     query_id_j;
  rob_id_t     query_id_k;
  logic        query_ready_j;
  logic        query_ready_k;
  logic [31:0] query_value_j;
  logic [31:0] query_value_k;

  logic        commit_valid;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value;
  rob_id_t     commit_RobId;
  logic        jump_flag;
  logic [31:0] jump_pc;

  modport master (
    output issue_valid, issue_rd, issue_is_branch, issue_pred_taken,
    output wb_valid, wb_RobId, wb_value, wb_taken, wb_target,
    output query_id_j, query_id_k,
    input  issue_RobId, rob_full, rename_valid,
    input  query_ready_j, query_ready_k, query_value_j, query_value_k,
    input  commit_valid, commit_dest, commit_value, commit_RobId, jump_flag, jump_pc
  );

  modport slave (
    input  issue_valid, issue_rd, issue_is_branch, issue_pred_taken,
    input  wb_valid, wb_RobId, wb_value, wb_taken, wb_target,
    input  query_id_j, query_id_k,
    output issue_RobId, rob_full, rename_valid,
    output query_ready_j, query_ready_k, query_value_j, query_value_k,
    output commit_valid, commit_dest, commit_value, commit_RobId, jump_flag, jump_pc
  );
endinterface

// File: rtl/rob_commit_ctrl_query_port.sv
// rtl/rob_commit_ctrl_query_port.sv - operand tag lookup with CDB bypass
// A tag is ready if its entry already holds a result or the CDB is broadcasting it now.
module rob_query_port
  import rob_commit_ctrl_pkg::*;
(
  input  rob_id_t             id_i,
  input  logic                wb_valid_i,
  input  rob_id_t             wb_id_i,
  input  logic [31:0]         wb_value_i,
  input  logic [ROB_SIZE-1:0] busy_i,
  input  logic [ROB_SIZE-1:0] ready_i,
  input  logic [31:0]         value_i [ROB_SIZE],
  output logic                ready_o,
  output logic [31:0]         value_o
);
  logic hit;

  assign hit     = wb_valid_i && (wb_id_i == id_i);
  assign ready_o = (busy_i[id_i] & ready_i[id_i]) | hit;
  assign value_o = hit ? wb_value_i : value_i[id_i];
endmodule

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - reorder buffer: allocate at issue, retire in order, flush on mispredict
// Entry state lives in parallel arrays indexed by ROB id; head retires, tail allocates.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  rob_commit_ctrl_if.slave bus
);
  logic [ROB_SIZE-1:0] busy_q, ready_q, is_br_q, pred_q, misp_q;
  logic [4:0]          dest_q   [ROB_SIZE];
  logic [31:0]         value_q  [ROB_SIZE];
  logic [31:0]         target_q [ROB_SIZE];
  rob_id_t             head_q, head_d, tail_q, tail_d;
  rob_cnt_t            count_q, count_d;

  logic rob_full, commit_valid, jump_flag, rename_valid;

  // Fullness is taken from the registered count, so a full ROB rejects issue even while retiring.
  assign rob_full     = (count_q == rob_cnt_t'(ROB_SIZE));
  assign commit_valid = rdy & busy_q[head_q] & ready_q[head_q];
  assign jump_flag    = commit_valid & misp_q[head_q];
  assign rename_valid = rdy & bus.issue_valid & ~rob_full & ~jump_flag;

  assign bus.issue_RobId  = tail_q;
  assign bus.rob_full     = rob_full;
  assign bus.rename_valid = rename_valid;
  assign bus.commit_valid = commit_valid;
  assign bus.commit_dest  = commit_valid ? dest_q[head_q]  : '0;
  assign bus.commit_value = commit_valid ? value_q[head_q] : '0;
  assign bus.commit_RobId = commit_valid ? head_q          : '0;
  assign bus.jump_flag    = jump_flag;
  assign bus.jump_pc      = jump_flag ? target_q[head_q] : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (jump_flag) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (rename_valid) tail_d = id_inc(tail_q);
      if (commit_valid) head_d = id_inc(head_q);
      case ({rename_valid, commit_valid})
        2'b10:   count_d = count_q + rob_cnt_t'(1);
        2'b01:   count_d = count_q - rob_cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      ready_q <= '0;
      is_br_q <= '0;
      pred_q  <= '0;
      misp_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        dest_q[i]   <= '0;
        value_q[i]  <= '0;
        target_q[i] <= '0;
      end
    end else if (rdy) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (jump_flag) begin
        // Flush discards every in-flight entry, including any same-cycle writeback.
        busy_q  <= '0;
        ready_q <= '0;
      end else begin
        if (bus.wb_valid && busy_q[bus.wb_RobId]) begin
          ready_q[bus.wb_RobId]  <= 1'b1;
          value_q[bus.wb_RobId]  <= bus.wb_value;
          target_q[bus.wb_RobId] <= bus.wb_target;
          misp_q[bus.wb_RobId]   <= is_br_q[bus.wb_RobId] & (bus.wb_taken != pred_q[bus.wb_RobId]);
        end
        if (commit_valid) busy_q[head_q] <= 1'b0;
        if (rename_valid) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          misp_q[tail_q]  <= 1'b0;
          dest_q[tail_q]  <= bus.issue_rd;
          is_br_q[tail_q] <= bus.issue_is_branch;
          pred_q[tail_q]  <= bus.issue_pred_taken;
        end
      end
    end
  end

  rob_query_port u_query_j (
    .id_i       (bus.query_id_j),
    .wb_valid_i (bus.wb_valid),
    .wb_id_i    (bus.wb_RobId),
    .wb_value_i (bus.wb_value),
    .busy_i     (busy_q),
    .ready_i    (ready_q),
    .value_i    (value_q),
    .ready_o    (bus.query_ready_j),
    .value_o    (bus.query_value_j)
  );

  rob_query_port u_query_k (
    .id_i       (bus.query_id_k),
    .wb_valid_i (bus.wb_valid),
    .wb_id_i    (bus.wb_RobId),
    .wb_value_i (bus.wb_value),
    .busy_i     (busy_q),
    .ready_i    (ready_q),
    .value_i    (value_q),
    .ready_o    (bus.query_ready_k),
    .value_o    (bus.query_value_k)
  );
endmodule
